// File: rtl/jedro_1_sig_monitor.sv
// Compliance signature monitor: snoops mailbox writes, then streams the signature region out of data memory.
// Optional cycle watchdog enabled by defining JEDRO_1_SIG_MON_TIMEOUT_EN.
module jedro_1_sig_monitor #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned MEM_SIZE_WORDS = 1 << 19,
   parameter int unsigned SIG_START_ADDR = (MEM_SIZE_WORDS - 1) * 4,
   parameter int unsigned SIG_END_ADDR   = (MEM_SIZE_WORDS - 2) * 4,
   parameter int unsigned HALT_ADDR      = (MEM_SIZE_WORDS - 3) * 4,
   parameter logic [31:0] TIMEOUT        = 32'd1000000
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic                              snoop_stb_i,
   input  logic [DATA_WIDTH/8-1:0]           snoop_we_i,
   input  logic [31:0]                       snoop_addr_i,
   input  logic [DATA_WIDTH-1:0]             snoop_wdata_i,
   input  logic                              snoop_ack_i,
   output logic                              mem_rd_en_o,
   output logic [$clog2(MEM_SIZE_WORDS)-1:0] mem_rd_addr_o,
   input  logic [DATA_WIDTH-1:0]             mem_rd_data_i,
   output logic                              sig_valid_o,
   output logic [DATA_WIDTH-1:0]             sig_data_o,
   output logic                              sig_last_o,
   input  logic                              sig_ready_i,
   output logic                              halted_o,
   output logic                              done_o,
   output logic                              timeout_o
);

   localparam int AW = $clog2(MEM_SIZE_WORDS);
   localparam int PW = AW + 2;
   localparam int NB = DATA_WIDTH / 8;

   localparam logic [31:0] START_MB = 32'(SIG_START_ADDR);
   localparam logic [31:0] END_MB   = 32'(SIG_END_ADDR);
   localparam logic [31:0] HALT_MB  = 32'(HALT_ADDR);

   typedef enum logic [2:0] {
      RUN,
      RD,
      WT,
      OUT,
      DONE,
      TMO
   } state_e;

   state_e                 stateQ, stateD;
   logic [PW-1:0]          startQ, startD;
   logic [PW-1:0]          endQ, endD;
   logic [DATA_WIDTH-1:0]  haltQ, haltD;
   logic [PW-1:0]          ptrQ, ptrD;
   logic [DATA_WIDTH-1:0]  dataQ, dataD;
   logic                   validQ, validD;
   logic                   haltedQ, haltedD;
   logic                   doneQ, doneD;

   logic                   writeHit;
   logic [31:0]            wordAddr;
   logic                   haltPending;
   logic                   wdogExpire;
   logic [PW:0]            ptrInc;
   logic [DATA_WIDTH-1:0]  startMerged;
   logic [DATA_WIDTH-1:0]  endMerged;

   function automatic logic [DATA_WIDTH-1:0] mergeLanes(
      input logic [DATA_WIDTH-1:0] oldVal,
      input logic [DATA_WIDTH-1:0] newVal,
      input logic [NB-1:0]         laneEn
   );
      logic [DATA_WIDTH-1:0] res;
      res = oldVal;
      for (int b = 0; b < NB; b++) begin
         if (laneEn[b]) res[b*8 +: 8] = newVal[b*8 +: 8];
      end
      return res;
   endfunction

   assign writeHit    = (stateQ == RUN) & snoop_stb_i & snoop_ack_i & (|snoop_we_i);
   assign wordAddr    = snoop_addr_i & ~32'h3;
   assign haltPending = (haltQ == DATA_WIDTH'(1));
   assign ptrInc      = {1'b0, ptrQ} + (PW+1)'(4);

   // Start/end shadows keep only the word-aligned bits that can address data memory.
   always_comb begin
      startMerged = mergeLanes(DATA_WIDTH'(startQ), snoop_wdata_i, snoop_we_i);
      endMerged   = mergeLanes(DATA_WIDTH'(endQ), snoop_wdata_i, snoop_we_i);
      startD      = startQ;
      endD        = endQ;
      haltD       = haltQ;
      if (writeHit && wordAddr == START_MB) startD = {startMerged[PW-1:2], 2'b00};
      if (writeHit && wordAddr == END_MB)   endD   = {endMerged[PW-1:2], 2'b00};
      if (writeHit && wordAddr == HALT_MB)  haltD  = mergeLanes(haltQ, snoop_wdata_i, snoop_we_i);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         startQ <= '0;
         endQ   <= '0;
         haltQ  <= '0;
      end else begin
         startQ <= startD;
         endQ   <= endD;
         haltQ  <= haltD;
      end
   end

`ifdef JEDRO_1_SIG_MON_TIMEOUT_EN
   logic [31:0] wdogQ, wdogD;
   logic        timeoutQ, timeoutD;

   always_comb begin
      wdogD      = wdogQ;
      wdogExpire = (stateQ == RUN) && (wdogQ == TIMEOUT - 32'd1);
      if (stateQ == RUN) wdogD = wdogQ + 32'd1;
      timeoutD   = timeoutQ | (stateD == TMO);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wdogQ    <= '0;
         timeoutQ <= 1'b0;
      end else begin
         wdogQ    <= wdogD;
         timeoutQ <= timeoutD;
      end
   end

   assign timeout_o = timeoutQ;
`else
   assign wdogExpire = 1'b0;
   assign timeout_o  = 1'b0;
`endif

   // Dump sequencer: halt takes priority over watchdog expiry in the same cycle.
   always_comb begin
      stateD      = stateQ;
      ptrD        = ptrQ;
      dataD       = dataQ;
      validD      = validQ;
      haltedD     = haltedQ;
      mem_rd_en_o = 1'b0;
      case (stateQ)
         RUN: begin
            if (haltPending) begin
               haltedD = 1'b1;
               ptrD    = startQ;
               stateD  = (endQ <= startQ) ? DONE : RD;
            end else if (wdogExpire) begin
               stateD = TMO;
            end
         end
         RD: begin
            mem_rd_en_o = 1'b1;
            stateD      = WT;
         end
         WT: begin
            dataD  = mem_rd_data_i;
            validD = 1'b1;
            stateD = OUT;
         end
         OUT: begin
            if (sig_ready_i) begin
               validD = 1'b0;
               ptrD   = ptrInc[PW-1:0];
               stateD = (ptrInc >= {1'b0, endQ}) ? DONE : RD;
            end
         end
         DONE: ;
         TMO: ;
         default: stateD = RUN;
      endcase
      doneD = doneQ | (stateQ == DONE) | (stateD == TMO);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stateQ  <= RUN;
         ptrQ    <= '0;
         dataQ   <= '0;
         validQ  <= 1'b0;
         haltedQ <= 1'b0;
         doneQ   <= 1'b0;
      end else begin
         stateQ  <= stateD;
         ptrQ    <= ptrD;
         dataQ   <= dataD;
         validQ  <= validD;
         haltedQ <= haltedD;
         doneQ   <= doneD;
      end
   end

   assign mem_rd_addr_o = ptrQ[PW-1:2];
   assign sig_valid_o   = validQ;
   assign sig_data_o    = dataQ;
   assign sig_last_o    = validQ & (ptrInc >= {1'b0, endQ});
   assign halted_o      = haltedQ;
   assign done_o        = doneQ;

endmodule

// File: tb/tb_jedro_1_sig_monitor.sv
// Scoreboard bench for jedro_1_sig_monitor: mailbox writes, memory model, stalling sink, reset and watchdog cases.
module tb_jedro_1_sig_monitor;

   localparam int DW  = 32;
   localparam int MSW = 1024;
   localparam int AW  = 10;
   localparam logic [31:0] START_MB = (MSW - 1) * 4;
   localparam logic [31:0] END_MB   = (MSW - 2) * 4;
   localparam logic [31:0] HALT_MB  = (MSW - 3) * 4;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic          snoop_stb_i = 1'b0;
   logic [3:0]    snoop_we_i = '0;
   logic [31:0]   snoop_addr_i = '0;
   logic [31:0]   snoop_wdata_i = '0;
   logic          snoop_ack_i = 1'b0;
   logic          mem_rd_en_o;
   logic [AW-1:0] mem_rd_addr_o;
   logic [DW-1:0] mem_rd_data_i = '0;
   logic          sig_valid_o;
   logic [DW-1:0] sig_data_o;
   logic          sig_last_o;
   logic          sig_ready_i = 1'b0;
   logic          halted_o;
   logic          done_o;
   logic          timeout_o;

   jedro_1_sig_monitor #(
      .DATA_WIDTH(DW),
      .MEM_SIZE_WORDS(MSW),
      .TIMEOUT(32'd50)
   ) dut (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .snoop_stb_i(snoop_stb_i),
      .snoop_we_i(snoop_we_i),
      .snoop_addr_i(snoop_addr_i),
      .snoop_wdata_i(snoop_wdata_i),
      .snoop_ack_i(snoop_ack_i),
      .mem_rd_en_o(mem_rd_en_o),
      .mem_rd_addr_o(mem_rd_addr_o),
      .mem_rd_data_i(mem_rd_data_i),
      .sig_valid_o(sig_valid_o),
      .sig_data_o(sig_data_o),
      .sig_last_o(sig_last_o),
      .sig_ready_i(sig_ready_i),
      .halted_o(halted_o),
      .done_o(done_o),
      .timeout_o(timeout_o)
   );

   initial forever #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] data;
      logic        last;
   } exp_t;

   exp_t        expQ[$];
   logic [31:0] mem[0:MSW-1];
   int          vecCount = 0;
   int          errCount = 0;
   int          wordsRx = 0;
   bit          validSeen = 0;
   int          readyMode = 0;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecCount++;
      if (obs !== exp) begin
         errCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Synchronous read port: data appears one cycle after the request, junk otherwise.
   initial forever begin
      @(posedge clk_i);
      if (mem_rd_en_o) mem_rd_data_i <= mem[mem_rd_addr_o];
      else             mem_rd_data_i <= 32'hDEAD_BEEF;
   end

   // Sink: drives ready for the coming edge, then scores any handshake about to happen.
   initial begin
      int          phase;
      logic        stalled;
      logic [31:0] held;
      exp_t        e;
      phase   = 0;
      stalled = 1'b0;
      held    = '0;
      forever begin
         @(negedge clk_i);
         if (readyMode == 0) sig_ready_i = 1'b1;
         else begin
            sig_ready_i = (phase == 0);
            phase = (phase + 1) % 4;
         end
         if (rst_i || !sig_valid_o) begin
            stalled = 1'b0;
         end else begin
            validSeen = 1'b1;
            if (stalled) checkOutput("stall_data", sig_data_o, held);
            if (sig_ready_i) begin
               checkOutput("queue_nonempty", 32'(expQ.size() > 0), 32'd1);
               if (expQ.size() > 0) begin
                  e = expQ.pop_front();
                  checkOutput("word_data", sig_data_o, e.data);
                  checkOutput("word_last", 32'(sig_last_o), 32'(e.last));
               end
               wordsRx++;
               stalled = 1'b0;
            end else begin
               stalled = 1'b1;
               held    = sig_data_o;
            end
         end
      end
   end

   task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] we);
      @(negedge clk_i);
      snoop_stb_i   = 1'b1;
      snoop_ack_i   = 1'b1;
      snoop_we_i    = we;
      snoop_addr_i  = addr;
      snoop_wdata_i = data;
      @(posedge clk_i);
      #1;
      snoop_stb_i = 1'b0;
      snoop_ack_i = 1'b0;
      snoop_we_i  = '0;
   endtask

   task automatic doReset();
      rst_i = 1'b1;
      expQ.delete();
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      rst_i     = 1'b0;
      wordsRx   = 0;
      validSeen = 1'b0;
   endtask

   task automatic waitDone(input int budget);
      int n;
      n = 0;
      while (!done_o && n < budget) begin
         @(posedge clk_i);
         #1;
         n++;
      end
      checkOutput("done_reached", 32'(done_o), 32'd1);
   endtask

   // Loads n words at byte address base, queues their expectations and triggers the dump.
   task automatic startDump(input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         exp_t e;
         mem[(base >> 2) + i] = 32'hA5C3_0000 ^ (i * 32'h0101_1111) ^ $urandom_range(0, 255);
         e.data = mem[(base >> 2) + i];
         e.last = (i == n - 1);
         expQ.push_back(e);
      end
      applyStimulus(START_MB, base, 4'hF);
      applyStimulus(END_MB, base + n * 4, 4'hF);
      applyStimulus(HALT_MB, 32'd1, 4'hF);
      checkOutput("halted_early", 32'(halted_o), 32'd0);
      @(posedge clk_i);
      #1;
      checkOutput("halted_rise", 32'(halted_o), 32'd1);
   endtask

   task automatic finishDump(input int n);
      waitDone(300);
      checkOutput("word_count", 32'(wordsRx), 32'(n));
      checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
      checkOutput("no_timeout", 32'(timeout_o), 32'd0);
   endtask

   initial begin
      int n;

      // Reset state
      doReset();
      checkOutput("rst_valid", 32'(sig_valid_o), 32'd0);
      checkOutput("rst_last", 32'(sig_last_o), 32'd0);
      checkOutput("rst_data", sig_data_o, 32'd0);
      checkOutput("rst_rden", 32'(mem_rd_en_o), 32'd0);
      checkOutput("rst_rdaddr", 32'(mem_rd_addr_o), 32'd0);
      checkOutput("rst_halted", 32'(halted_o), 32'd0);
      checkOutput("rst_done", 32'(done_o), 32'd0);
      checkOutput("rst_timeout", 32'(timeout_o), 32'd0);

      // Three words with ready held high
      readyMode = 0;
      startDump(32'h100, 3);
      finishDump(3);

      // Same region with a stalling sink
      doReset();
      readyMode = 1;
      startDump(32'h100, 3);
      finishDump(3);
      readyMode = 0;

      // Empty region: no stream, done one cycle after halted
      doReset();
      applyStimulus(START_MB, 32'h200, 4'hF);
      applyStimulus(END_MB, 32'h200, 4'hF);
      applyStimulus(HALT_MB, 32'd1, 4'hF);
      @(posedge clk_i);
      #1;
      checkOutput("empty_halted", 32'(halted_o), 32'd1);
      checkOutput("empty_done_early", 32'(done_o), 32'd0);
      @(posedge clk_i);
      #1;
      checkOutput("empty_done", 32'(done_o), 32'd1);
      repeat (5) @(posedge clk_i);
      checkOutput("empty_no_valid", 32'(validSeen), 32'd0);

      // Byte-lane halt writes
      doReset();
      applyStimulus(HALT_MB, 32'h0000_0001, 4'b0001);
      applyStimulus(HALT_MB, 32'h0000_0000, 4'b1110);
      checkOutput("lane0_halt", 32'(halted_o), 32'd1);
      doReset();
      applyStimulus(HALT_MB, 32'h0000_0100, 4'b0011);
      repeat (5) @(posedge clk_i);
      #1;
      checkOutput("lane1_nohalt", 32'(halted_o), 32'd0);
      doReset();
      applyStimulus(HALT_MB | 32'h2, 32'h0000_0001, 4'b0001);
      @(posedge clk_i);
      #1;
      checkOutput("masked_addr_halt", 32'(halted_o), 32'd1);

      // Watchdog with no halt ever written
      doReset();
`ifdef JEDRO_1_SIG_MON_TIMEOUT_EN
      repeat (49) @(posedge clk_i);
      #1;
      checkOutput("tmo_early", 32'(timeout_o), 32'd0);
      checkOutput("tmo_done_early", 32'(done_o), 32'd0);
      @(posedge clk_i);
      #1;
      checkOutput("tmo_rise", 32'(timeout_o), 32'd1);
      checkOutput("tmo_done", 32'(done_o), 32'd1);
`else
      repeat (200) @(posedge clk_i);
      #1;
      checkOutput("no_wdog_timeout", 32'(timeout_o), 32'd0);
      checkOutput("no_wdog_done", 32'(done_o), 32'd0);
`endif
      checkOutput("tmo_no_stream", 32'(validSeen), 32'd0);

      // Reset in the middle of a 4-word dump, then a clean rerun
      doReset();
      startDump(32'h300, 4);
      n = 0;
      while (wordsRx < 2 && n < 100) begin
         @(posedge clk_i);
         n++;
      end
      checkOutput("reach_word2", 32'(wordsRx >= 2), 32'd1);
      #1;
      rst_i = 1'b1;
      #1;
      checkOutput("mid_rst_valid", 32'(sig_valid_o), 32'd0);
      checkOutput("mid_rst_rden", 32'(mem_rd_en_o), 32'd0);
      checkOutput("mid_rst_last", 32'(sig_last_o), 32'd0);
      checkOutput("mid_rst_halted", 32'(halted_o), 32'd0);
      checkOutput("mid_rst_done", 32'(done_o), 32'd0);
      checkOutput("mid_rst_data", sig_data_o, 32'd0);
      doReset();
      startDump(32'h300, 4);
      finishDump(4);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
      $finish;
   end

endmodule

// File: doc/jedro_1_sig_monitor.md
# jedro_1_sig_monitor

Synthesisable successor to the simulation-only signature dump used for compliance runs. It snoops the core's data bus for writes to three mailbox words (signature start, signature end, halt). When halt is written it reads the signature region out of data memory through a dedicated read port and streams it word by word over a valid/ready interface, which feeds a UART or a bench sink. A cycle watchdog flags runs that never halt.

## Interface
Parameters:
- DATA_WIDTH, 32, bus and signature word width (multiple of 8)
- MEM_SIZE_WORDS, 1<<19, data memory depth in words; AW = $clog2(MEM_SIZE_WORDS)
- SIG_START_ADDR, (MEM_SIZE_WORDS-1)*4, byte address of start mailbox
- SIG_END_ADDR, (MEM_SIZE_WORDS-2)*4, byte address of end mailbox
- HALT_ADDR, (MEM_SIZE_WORDS-3)*4, byte address of halt mailbox
- TIMEOUT, 1000000, watchdog limit in cycles (32-bit)

Ports:
- clk_i  in  1  clock; all state on rising edge
- rst_i  in  1  asynchronous, active-high reset
- snoop_stb_i  in  1  data bus strobe
- snoop_we_i  in  DATA_WIDTH/8  byte write enables
- snoop_addr_i  in  32  data bus byte address
- snoop_wdata_i  in  DATA_WIDTH  write data
- snoop_ack_i  in  1  memory ack; a write counts only when stb & ack & |we
- mem_rd_en_o  out  1  read request to the memory's second port
- mem_rd_addr_o  out  AW  word address
- mem_rd_data_i  in  DATA_WIDTH  read data, valid exactly 1 cycle after mem_rd_en_o
- sig_valid_o  out  1  signature word available
- sig_data_o  out  DATA_WIDTH  signature word
- sig_last_o  out  1  qualifies the final word
- sig_ready_i  in  1  sink accepts the word
- halted_o  out  1  halt mailbox reached 1
- done_o  out  1  dump finished or timed out; sticky
- timeout_o  out  1  watchdog expired; sticky

## Operation
- Three shadow registers (start, end, halt) are cleared to 0 by reset. A counted write whose address matches a mailbox (full-word compare after masking addr[1:0]) merges wdata into that shadow per byte lane.
- Address use: the start and end shadows are truncated to AW+2 bits and aligned down to a word boundary.
- States:
  - RUN: snooping active. The cycle after the halt shadow becomes exactly 1: ptr <= start and halted_o=1. If end <= start, go to DONE; otherwise go to RD.
  - RD: assert mem_rd_en_o with mem_rd_addr_o=ptr>>2 for one cycle, then go to WT.
  - WT: capture mem_rd_data_i into sig_data_o, set sig_valid_o, then go to OUT.
  - OUT: hold valid and data stable until sig_ready_i. On handshake, ptr += 4. If the new ptr >= end, go to DONE; otherwise go to RD.
  - DONE: done_o=1, idle until reset.
  - TMO: timeout_o=1 and done_o=1, no stream, idle until reset.
- sig_last_o = sig_valid_o & (ptr+4 >= end).
- Snooping is disabled outside RUN. Later mailbox writes are ignored.
- Word count is (end-start)/4 after alignment.

## Timing
- Reset values: all outputs 0; state RUN; ptr 0; watchdog 0.
- Mailbox write to halted_o: 2 cycles (shadow update, then state transition).
- Per word: RD to valid is 2 cycles. With sig_ready_i held high, throughput is one word per 3 cycles.
- The sink may hold ready low indefinitely. Data must not change while valid & !ready.
- Simultaneous halt detection and watchdog expiry in the same cycle: halt wins.
- Reset asserted mid-dump clears sig_valid_o and mem_rd_en_o immediately (asynchronous). The stream is abandoned without a last flag.
- end equal to start produces zero words: done_o rises 1 cycle after halted_o.

## Configuration
- JEDRO_1_SIG_MON_TIMEOUT_EN defined:
  - A 32-bit watchdog counts every cycle in RUN.
  - When the count equals TIMEOUT-1 and no halt is pending, the next state is TMO.
- Not defined:
  - No counter is synthesised and timeout_o is tied 0.
  - RUN waits for halt indefinitely.

## Test plan
- Write start=0x100, end=0x10C, halt=1, with memory words 0x40..0x42 = A,B,C and ready held high -> exactly 3 words A,B,C, last only on C, done_o=1.
- Same region with ready toggling 1 cycle on / 3 cycles off -> same 3 words, data stable while stalled, no duplicated or dropped words.
- Write start=0x200, end=0x200, halt=1 -> no sig_valid_o, done_o 1 cycle after halted_o.
- Byte-lane writes 0x01 to lane 0 of the halt mailbox, then other lanes zero -> halt detected. Writing 0x0100 instead -> no halt.
- With the macro defined, TIMEOUT=50 and no halt -> timeout_o and done_o rise at cycle 50, no stream. Without the macro -> never rise.
- Assert rst_i after the second of 4 words is accepted -> all outputs 0 at once. Rerun the full sequence -> a complete 4-word dump.
